// File: rtl/register_mode_cfg.sv
// register_mode_cfg: config-bus endpoint for a bank of RegisterMode lanes.
// Takes single-beat read/write requests over valid/ready. Holds the per-lane mode and
// const_ registers, emits one-cycle config_we/config_data pulses into the lanes, and
// returns read data and error status over a valid/ready response channel.
// Optional feature macro: REGISTER_MODE_CFG_PARITY_EN adds an even-parity check on requests.
module register_mode_cfg #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                        CLK,
    input  logic                        ASYNCRESETN,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic                        cfg_write,
    input  logic [ADDR_WIDTH-1:0]       cfg_addr,
    input  logic [WIDTH-1:0]            cfg_wdata,
`ifdef REGISTER_MODE_CFG_PARITY_EN
    input  logic                        cfg_parity,
`endif
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [WIDTH-1:0]            rsp_rdata,
    output logic                        rsp_err,
    input  logic [NUM_LANES*WIDTH-1:0]  lane_value,
    output logic [2*NUM_LANES-1:0]      mode,
    output logic [NUM_LANES*WIDTH-1:0]  const_,
    output logic [NUM_LANES-1:0]        config_we,
    output logic [WIDTH-1:0]            config_data
);

    localparam logic [1:0] FieldMode  = 2'd0;
    localparam logic [1:0] FieldConst = 2'd1;
    localparam logic [1:0] FieldReg   = 2'd2;

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e state_q, state_d;

    logic [2*NUM_LANES-1:0]     mode_q;
    logic [NUM_LANES*WIDTH-1:0] const_q;
    logic [NUM_LANES-1:0]       config_we_q;
    logic [WIDTH-1:0]           config_data_q;
    logic [WIDTH-1:0]           rsp_rdata_q;
    logic                       rsp_err_q;

    logic [ADDR_WIDTH-3:0]      req_lane;
    logic [1:0]                 req_field;
    logic [NUM_LANES-1:0]       lane_sel;
    logic                       lane_ok;
    logic                       parity_err;
    logic                       req_err;
    logic                       accept;
    logic                       do_write;
    logic [WIDTH-1:0]           rd_data;

    // Request decode: lane one-hot select, error classification and read mux.
    always_comb begin
        req_lane  = cfg_addr[ADDR_WIDTH-1:2];
        req_field = cfg_addr[1:0];
        lane_sel  = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_sel[i] = (32'(req_lane) == i);
        end
        // An address beyond the populated lanes selects nothing.
        lane_ok = |lane_sel;
`ifdef REGISTER_MODE_CFG_PARITY_EN
        parity_err = (cfg_parity != (^{cfg_write, cfg_addr, cfg_wdata}));
`else
        parity_err = 1'b0;
`endif
        req_err = !lane_ok
                || (req_field == 2'd3)
                || (cfg_write && (req_field == FieldMode) && (cfg_wdata[1:0] == 2'b11))
                || parity_err;
        accept   = cfg_valid && (state_q == StIdle);
        do_write = accept && cfg_write && !req_err;

        rd_data = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (lane_sel[i]) begin
                case (req_field)
                    FieldMode:  rd_data[1:0] = mode_q[2*i +: 2];
                    FieldConst: rd_data      = const_q[i*WIDTH +: WIDTH];
                    FieldReg:   rd_data      = lane_value[i*WIDTH +: WIDTH];
                    default:    rd_data      = '0;
                endcase
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one request in flight, released by the response handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (cfg_valid) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        cfg_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
    end

    // Response payload captured at accept and held until the handshake.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            rsp_err_q   <= req_err;
            rsp_rdata_q <= (req_err || cfg_write) ? '0 : rd_data;
        end
    end

    // Per-lane mode and const_ registers.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            mode_q  <= '0;
            const_q <= '0;
        end else if (do_write) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (lane_sel[i]) begin
                    if (req_field == FieldMode) begin
                        mode_q[2*i +: 2] <= cfg_wdata[1:0];
                    end
                    if (req_field == FieldConst) begin
                        const_q[i*WIDTH +: WIDTH] <= cfg_wdata;
                    end
                end
            end
        end
    end

    // Lane write strobe: self-clearing, so it lasts exactly the first response cycle.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            config_we_q   <= '0;
            config_data_q <= '0;
        end else begin
            config_we_q <= '0;
            if (do_write && (req_field == FieldReg)) begin
                config_we_q   <= lane_sel;
                config_data_q <= cfg_wdata;
            end
        end
    end

    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign mode        = mode_q;
    assign const_      = const_q;
    assign config_we   = config_we_q;
    assign config_data = config_data_q;

endmodule

// File: tb/tb_register_mode_cfg.sv
// Testbench for register_mode_cfg: directed scenarios plus randomized traffic checked
// against a field-map model of the lane registers.
module tb_register_mode_cfg;

    localparam int unsigned NL = 4;
    localparam int unsigned W  = 4;
    localparam int unsigned AW = 4;
    localparam int unsigned NL3 = 3;

    logic CLK = 1'b0;
    logic ASYNCRESETN = 1'b0;

    logic            cfg_valid = 1'b0, cfg_ready, cfg_write = 1'b0;
    logic [AW-1:0]   cfg_addr = '0;
    logic [W-1:0]    cfg_wdata = '0;
    logic            rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [W-1:0]    rsp_rdata;
    logic [NL*W-1:0] lane_value = '0;
    logic [2*NL-1:0] mode;
    logic [NL*W-1:0] const_;
    logic [NL-1:0]   config_we;
    logic [W-1:0]    config_data;

    logic             c3_valid = 1'b0, c3_ready, c3_write = 1'b0;
    logic [AW-1:0]    c3_addr = '0;
    logic [W-1:0]     c3_wdata = '0;
    logic             c3_rsp_valid, c3_rsp_ready = 1'b0, c3_rsp_err;
    logic [W-1:0]     c3_rdata;
    logic [NL3*W-1:0] c3_lane_value = '0;
    logic [2*NL3-1:0] c3_mode;
    logic [NL3*W-1:0] c3_const;
    logic [NL3-1:0]   c3_we;
    logic [W-1:0]     c3_data;

`ifdef REGISTER_MODE_CFG_PARITY_EN
    logic cfg_parity, c3_parity;
    assign cfg_parity = ^{cfg_write, cfg_addr, cfg_wdata};
    assign c3_parity  = ^{c3_write, c3_addr, c3_wdata};
`endif

    register_mode_cfg #(.NUM_LANES(NL), .WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_write(cfg_write),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
`ifdef REGISTER_MODE_CFG_PARITY_EN
        .cfg_parity(cfg_parity),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .lane_value(lane_value), .mode(mode), .const_(const_),
        .config_we(config_we), .config_data(config_data)
    );

    register_mode_cfg #(.NUM_LANES(NL3), .WIDTH(W), .ADDR_WIDTH(AW)) dut3 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .cfg_valid(c3_valid), .cfg_ready(c3_ready), .cfg_write(c3_write),
        .cfg_addr(c3_addr), .cfg_wdata(c3_wdata),
`ifdef REGISTER_MODE_CFG_PARITY_EN
        .cfg_parity(c3_parity),
`endif
        .rsp_valid(c3_rsp_valid), .rsp_ready(c3_rsp_ready), .rsp_rdata(c3_rdata),
        .rsp_err(c3_rsp_err), .lane_value(c3_lane_value), .mode(c3_mode), .const_(c3_const),
        .config_we(c3_we), .config_data(c3_data)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model of the register file.
    logic [1:0]   m_mode [NL];
    logic [W-1:0] m_const [NL];
    logic [W-1:0] m_cfg_data;
    logic         exp_err;
    logic [W-1:0] exp_rdata;
    logic [NL-1:0] exp_we;

    function automatic logic [2*NL-1:0] pack_mode();
        logic [2*NL-1:0] r;
        for (int i = 0; i < NL; i++) r[2*i +: 2] = m_mode[i];
        return r;
    endfunction

    function automatic logic [NL*W-1:0] pack_const();
        logic [NL*W-1:0] r;
        for (int i = 0; i < NL; i++) r[i*W +: W] = m_const[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_mode[i]  = '0;
            m_const[i] = '0;
        end
        m_cfg_data = '0;
    endtask

    // Applies one request to the model and produces the expected response.
    task automatic model_req(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
        int lane;
        int field;
        lane      = int'(a) / 4;
        field     = int'(a) % 4;
        exp_we    = '0;
        exp_rdata = '0;
        exp_err   = (lane >= NL) || (field == 3) || (w && field == 0 && d[1:0] == 2'b11);
        if (!exp_err) begin
            if (w) begin
                if (field == 0) m_mode[lane] = d[1:0];
                if (field == 1) m_const[lane] = d;
                if (field == 2) begin
                    exp_we[lane] = 1'b1;
                    m_cfg_data   = d;
                end
            end else begin
                if (field == 0) exp_rdata[1:0] = m_mode[lane];
                if (field == 1) exp_rdata = m_const[lane];
                if (field == 2) exp_rdata = lane_value[lane*W +: W];
            end
        end
    endtask

    // Presents one request and returns #1 after the accepting edge. Called at posedge+1.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
        int n;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL ready_timeout: cfg_ready=%b after %0d cycles, required 1", cfg_ready, n);
        end
        cfg_valid = 1'b1; cfg_write = w; cfg_addr = a; cfg_wdata = d;
        model_req(w, a, d);
        @(posedge CLK); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++;
            $display("FAIL rst_ready: got %b need 1", cfg_ready); end
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin errors++;
            $display("FAIL rst_rsp: got %b/%b/%h need 0", rsp_valid, rsp_err, rsp_rdata); end
        checks++; if ({mode, const_, config_we, config_data} !== '0) begin errors++;
            $display("FAIL rst_regs: got %h/%h/%b/%h need 0", mode, const_, config_we, config_data); end
        #12 ASYNCRESETN = 1'b1;
        @(posedge CLK); #1;
        issue(1'b0, 4'h0, 4'h0);
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 4'h0) begin errors++;
            $display("FAIL rst_read: got v=%b e=%b d=%h need 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
        release_rsp();
        checks++; if (rsp_valid !== 1'b0 || cfg_ready !== 1'b1) begin errors++;
            $display("FAIL rst_handshake: got v=%b r=%b need 0/1", rsp_valid, cfg_ready); end
    endtask

    task automatic test_const_rw();
        issue(1'b1, {2'd2, 2'd1}, 4'hA);
        checks++; if (const_[8 +: 4] !== 4'hA || rsp_err !== 1'b0) begin errors++;
            $display("FAIL const_write: got %h e=%b need a/0", const_[8 +: 4], rsp_err); end
        release_rsp();
        issue(1'b0, {2'd2, 2'd1}, 4'h0);
        checks++; if (rsp_rdata !== 4'hA || rsp_err !== 1'b0) begin errors++;
            $display("FAIL const_read: got %h e=%b need a/0", rsp_rdata, rsp_err); end
        release_rsp();
    endtask

    task automatic test_strobe();
        issue(1'b1, {2'd1, 2'd2}, 4'h5);
        checks++; if (config_we !== 4'b0010 || config_data !== 4'h5 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL strobe_first: got we=%b d=%h v=%b need 0010/5/1",
                     config_we, config_data, rsp_valid); end
        @(posedge CLK); #1;
        checks++; if (config_we !== 4'b0000 || rsp_valid !== 1'b1) begin errors++;
            $display("FAIL strobe_once: got we=%b v=%b need 0000/1", config_we, rsp_valid); end
        release_rsp();
        checks++; if (config_data !== 4'h5 || config_we !== 4'b0000) begin errors++;
            $display("FAIL strobe_hold: got d=%h we=%b need 5/0000", config_data, config_we); end
    endtask

    task automatic test_errors();
        issue(1'b1, {2'd0, 2'd0}, 4'h2);
        release_rsp();
        issue(1'b1, {2'd0, 2'd0}, 4'h3);
        checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 4'h0 || mode[1:0] !== 2'd2) begin errors++;
            $display("FAIL mode3_err: got e=%b d=%h m=%h need 1/0/2", rsp_err, rsp_rdata, mode[1:0]); end
        release_rsp();
        issue(1'b1, {2'd0, 2'd3}, 4'hF);
        checks++; if (rsp_err !== 1'b1 || config_we !== '0) begin errors++;
            $display("FAIL field3_wr: got e=%b we=%b need 1/0", rsp_err, config_we); end
        release_rsp();
        issue(1'b0, {2'd0, 2'd3}, 4'h0);
        checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 4'h0) begin errors++;
            $display("FAIL field3_rd: got e=%b d=%h need 1/0", rsp_err, rsp_rdata); end
        release_rsp();
    endtask

    task automatic test_hold();
        lane_value = {4'h7, 12'(($urandom))};
        issue(1'b0, {2'd3, 2'd2}, 4'h0);
        checks++; if (rsp_rdata !== 4'h7) begin errors++;
            $display("FAIL hold_first: got %h need 7", rsp_rdata); end
        for (int i = 0; i < 5; i++) begin
            lane_value = 16'($urandom);
            cfg_valid = 1'b1; cfg_write = 1'b1; cfg_addr = {2'd0, 2'd1}; cfg_wdata = 4'hC;
            @(posedge CLK); #1;
            checks++;
            if (rsp_rdata !== 4'h7 || rsp_valid !== 1'b1 || cfg_ready !== 1'b0
                || const_[3:0] !== m_const[0]) begin
                errors++;
                $display("FAIL hold_stall%0d: got d=%h v=%b r=%b c=%h need 7/1/0/%h",
                         i, rsp_rdata, rsp_valid, cfg_ready, const_[3:0], m_const[0]);
            end
        end
        cfg_valid = 1'b0;
        release_rsp();
        checks++; if (const_[3:0] !== m_const[0] || cfg_ready !== 1'b1) begin errors++;
            $display("FAIL hold_ignored: got c=%h r=%b need %h/1", const_[3:0], cfg_ready, m_const[0]); end
    endtask

    task automatic test_lane_range();
        c3_lane_value = 12'($urandom);
        c3_valid = 1'b1; c3_write = 1'b1; c3_addr = {2'd3, 2'd2}; c3_wdata = 4'h6;
        @(posedge CLK); #1;
        c3_valid = 1'b0;
        checks++;
        if (c3_rsp_valid !== 1'b1 || c3_rsp_err !== 1'b1 || c3_we !== '0 || c3_rdata !== '0
            || c3_data !== '0) begin
            errors++;
            $display("FAIL lane3_wr: got v=%b e=%b we=%b d=%h cd=%h need 1/1/0/0/0",
                     c3_rsp_valid, c3_rsp_err, c3_we, c3_rdata, c3_data);
        end
        c3_rsp_ready = 1'b1; @(posedge CLK); #1; c3_rsp_ready = 1'b0;
        c3_valid = 1'b1; c3_write = 1'b0; c3_addr = {2'd3, 2'd1};
        @(posedge CLK); #1;
        c3_valid = 1'b0;
        checks++; if (c3_rsp_err !== 1'b1 || c3_rdata !== '0) begin errors++;
            $display("FAIL lane3_rd: got e=%b d=%h need 1/0", c3_rsp_err, c3_rdata); end
        c3_rsp_ready = 1'b1; @(posedge CLK); #1; c3_rsp_ready = 1'b0;
        c3_valid = 1'b1; c3_write = 1'b1; c3_addr = {2'd2, 2'd1}; c3_wdata = 4'h6;
        @(posedge CLK); #1;
        c3_valid = 1'b0;
        checks++; if (c3_rsp_err !== 1'b0 || c3_const[8 +: 4] !== 4'h6) begin errors++;
            $display("FAIL lane2_ok: got e=%b c=%h need 0/6", c3_rsp_err, c3_const[8 +: 4]); end
        c3_rsp_ready = 1'b1; @(posedge CLK); #1; c3_rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic         w;
        logic [AW-1:0] a;
        logic [W-1:0] d;
        int stall;
        for (int n = 0; n < 300; n++) begin
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom);
            d = W'($urandom);
            lane_value = 16'($urandom);
            issue(w, a, d);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_rdata !== exp_rdata
                || config_we !== exp_we) begin
                errors++;
                $display("FAIL rnd_rsp%0d: got v=%b e=%b d=%h we=%b need 1/%b/%h/%b",
                         n, rsp_valid, rsp_err, rsp_rdata, config_we, exp_err, exp_rdata, exp_we);
            end
            checks++;
            if (mode !== pack_mode() || const_ !== pack_const() || config_data !== m_cfg_data) begin
                errors++;
                $display("FAIL rnd_regs%0d: got m=%h c=%h cd=%h need %h/%h/%h", n, mode, const_,
                         config_data, pack_mode(), pack_const(), m_cfg_data);
            end
            stall = $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) begin
                lane_value = 16'($urandom);
                @(posedge CLK); #1;
                checks++; if (rsp_rdata !== exp_rdata || config_we !== '0) begin errors++;
                    $display("FAIL rnd_stall%0d: got d=%h we=%b need %h/0", n, rsp_rdata,
                             config_we, exp_rdata); end
            end
            release_rsp();
            checks++; if (rsp_valid !== 1'b0 || cfg_ready !== 1'b1) begin errors++;
                $display("FAIL rnd_done%0d: got v=%b r=%b need 0/1", n, rsp_valid, cfg_ready); end
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, {2'd3, 2'd1}, 4'h9);
        release_rsp();
        issue(1'b0, {2'd3, 2'd1}, 4'h0);
        checks++; if (rsp_rdata !== 4'h9 || rsp_err !== 1'b0) begin errors++;
            $display("FAIL b2b_read: got %h e=%b need 9/0", rsp_rdata, rsp_err); end
        release_rsp();
    endtask

    task automatic test_reset_mid_resp();
        issue(1'b1, {2'd2, 2'd2}, 4'h9);
        checks++; if (config_we !== 4'b0100) begin errors++;
            $display("FAIL mid_strobe: got %b need 0100", config_we); end
        #2 ASYNCRESETN = 1'b0;
        #1;
        model_reset();
        checks++;
        if (rsp_valid !== 1'b0 || config_we !== '0 || cfg_ready !== 1'b1 || rsp_err !== 1'b0
            || rsp_rdata !== '0 || mode !== '0 || const_ !== '0 || config_data !== '0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b we=%b r=%b e=%b d=%h m=%h c=%h cd=%h need all 0, r=1",
                     rsp_valid, config_we, cfg_ready, rsp_err, rsp_rdata, mode, const_, config_data);
        end
        #2 ASYNCRESETN = 1'b1;
        @(posedge CLK); #1;
        issue(1'b0, {2'd1, 2'd1}, 4'h0);
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 4'h0 || rsp_err !== 1'b0) begin errors++;
            $display("FAIL post_reset: got v=%b d=%h e=%b need 1/0/0", rsp_valid, rsp_rdata, rsp_err); end
        release_rsp();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_const_rw();
        test_strobe();
        test_errors();
        test_hold();
        test_lane_range();
        test_back_to_back();
        test_random();
        test_reset_mid_resp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
